// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: op codes, FSM states and
// a helper that classifies the multi-cycle multiply/divide ops.
package alu_pkg;

    typedef logic [3:0] op_t;

    localparam op_t OP_ADD   = 4'd0;
    localparam op_t OP_SUB   = 4'd1;
    localparam op_t OP_AND   = 4'd2;
    localparam op_t OP_OR    = 4'd3;
    localparam op_t OP_XOR   = 4'd4;
    localparam op_t OP_NOR   = 4'd5;
    localparam op_t OP_LUI   = 4'd6;
    localparam op_t OP_SLT   = 4'd7;
    localparam op_t OP_SLTU  = 4'd8;
    localparam op_t OP_SLL   = 4'd9;
    localparam op_t OP_SRL   = 4'd10;
    localparam op_t OP_SRA   = 4'd11;
    localparam op_t OP_MULT  = 4'd12;
    localparam op_t OP_MULTU = 4'd13;
    localparam op_t OP_DIV   = 4'd14;
    localparam op_t OP_DIVU  = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Ops 12..15 share the top two code bits; the low two bits then select
    // mul/div (bit 1) and signed/unsigned (bit 0).
    function automatic logic is_muldiv(input op_t op);
        return op[3:2] == 2'b11;
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between the pipeline and the ALU.
//
// Handshake: a request transfers on a rising clock edge where in_valid and
// in_ready are both 1. While in_ready is 0 the requester keeps in_valid, op
// and operands stable and the ALU ignores them. There is no response
// backpressure: out_valid is a one-cycle pulse qualifying result/zero/ovf.
interface seq_alu_if #(parameter int WIDTH = 32);
    import alu_pkg::*;

    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    op_t              op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output in_valid, op, x, y, shamt,
        input  in_ready, out_valid, result, zero, ovf, hi, lo
    );

    modport slave (
        input  in_valid, op, x, y, shamt,
        output in_ready, out_valid, result, zero, ovf, hi, lo
    );

endinterface

// File: rtl/seq_alu_mdu.sv
// Iterative multiply/divide unit. One shared accumulator/low-word pair runs
// either shift-add multiplication or restoring division on operand
// magnitudes for exactly WIDTH iterations; signs are fixed up afterwards.
// done and the corrected hi_out/lo_out are combinational on the final
// iteration so the parent can register them on the same edge.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,      // bit1: divide, bit0: unsigned
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] low_q, low_d;
    logic [WIDTH-1:0] opb_q, opb_d;

    logic             a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] step_acc, step_low;
    logic [2*WIDTH-1:0] prod;

    // Operand magnitudes and sign bookkeeping for the start of an operation.
    always_comb begin : operand_prep
        a_neg  = ~op[0] & a[WIDTH-1];
        b_neg  = ~op[0] & b[WIDTH-1];
        b_zero = (b == '0);
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
    end

    // One iteration of the shared datapath: the low word doubles as the
    // multiplier (shifted right) or the dividend/quotient (shifted left).
    always_comb begin : iteration
        mul_sum   = {1'b0, acc_q} + (low_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_q, low_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        // When div_ge holds the true difference is below the divisor, so the
        // low WIDTH bits are exact.
        div_diff  = div_shift[WIDTH-1:0] - opb_q;
        if (is_div_q) begin
            step_acc = div_ge ? div_diff : div_shift[WIDTH-1:0];
            step_low = {low_q[WIDTH-2:0], div_ge};
        end else begin
            step_acc = mul_sum[WIDTH:1];
            step_low = {mul_sum[0], low_q[WIDTH-1:1]};
        end
    end

    // Sign post-correction applied to the final iteration's value.
    always_comb begin : post_correct
        prod = {step_acc, step_low};
        if (neg_q) begin
            prod = -prod;
        end
        if (is_div_q) begin
            lo_out = neg_q ? -step_low : step_low;
            hi_out = rem_neg_q ? -step_acc : step_acc;
        end else begin
            hi_out = prod[2*WIDTH-1:WIDTH];
            lo_out = prod[WIDTH-1:0];
        end
        done = busy_q && (cnt_q == LAST);
    end

    // Next-state: load on start, otherwise iterate while busy.
    always_comb begin : next_state
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        acc_d     = acc_q;
        low_d     = low_q;
        opb_d     = opb_q;
        if (start) begin
            busy_d    = 1'b1;
            cnt_d     = '0;
            is_div_d  = op[1];
            // Divide by zero keeps the all-ones quotient unsigned-looking.
            neg_d     = (a_neg ^ b_neg) & ~(op[1] & b_zero);
            rem_neg_d = op[1] & a_neg;
            acc_d     = '0;
            low_d     = a_mag;
            opb_d     = b_mag;
        end else if (busy_q) begin
            acc_d = step_acc;
            low_d = step_low;
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State registers; reset discards any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            acc_q     <= '0;
            low_q     <= '0;
            opb_q     <= '0;
        end else begin
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            acc_q     <= acc_d;
            low_q     <= low_d;
            opb_q     <= opb_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered execute-stage ALU with HI/LO registers. Single-cycle ops return
// one cycle after acceptance; mul/div ops hand off to mdu_iter and hold
// in_ready low until HI/LO have been written.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic   clk,
    input  logic   rst_n,
    seq_alu_if.slave bus,
    output state_t dbg_state
);

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             accept;
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_hi, md_lo;
    logic [WIDTH-1:0] add_res, sub_res;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    mdu_iter #(.WIDTH(WIDTH)) u_mdu (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .op     (bus.op[1:0]),
        .a      (bus.x),
        .b      (bus.y),
        .done   (md_done),
        .hi_out (md_hi),
        .lo_out (md_lo)
    );

    // Single-cycle datapath evaluated on the presented request.
    always_comb begin : single_cycle
        add_res = bus.x + bus.y;
        sub_res = bus.x - bus.y;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.op)
            OP_ADD: begin
                alu_res = add_res;
                alu_ovf = (bus.x[WIDTH-1] == bus.y[WIDTH-1]) &&
                          (add_res[WIDTH-1] != bus.x[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_res;
                alu_ovf = (bus.x[WIDTH-1] != bus.y[WIDTH-1]) &&
                          (sub_res[WIDTH-1] != bus.x[WIDTH-1]);
            end
            OP_AND:  alu_res = bus.x & bus.y;
            OP_OR:   alu_res = bus.x | bus.y;
            OP_XOR:  alu_res = bus.x ^ bus.y;
            OP_NOR:  alu_res = ~(bus.x | bus.y);
            OP_LUI:  alu_res = {bus.y[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.x) < $signed(bus.y)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, bus.x < bus.y};
            OP_SLL:  alu_res = bus.y << bus.shamt;
            OP_SRL:  alu_res = bus.y >> bus.shamt;
            OP_SRA:  alu_res = $signed(bus.y) >>> bus.shamt;
            default: alu_res = '0;
        endcase
    end

    // Handshake and FSM next-state; outputs are registered below.
    always_comb begin : control
        accept      = bus.in_valid && (state_q == S_IDLE);
        md_start    = accept && is_muldiv(bus.op);
        state_d     = state_q;
        out_valid_d = 1'b0;
        result_d    = result_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_muldiv(bus.op)) begin
                        state_d = S_BUSY;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_res;
                        zero_d      = (alu_res == '0);
                        ovf_d       = alu_ovf;
                    end
                end
            end
            S_BUSY: begin
                if (md_done) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    hi_d        = md_hi;
                    lo_d        = md_lo;
                    result_d    = md_lo;
                    zero_d      = (md_lo == '0);
                    ovf_d       = 1'b0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state and all output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            ovf_q       <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed vector table, multi-cycle corner sequences and
// random ops checked against an arithmetic reference model.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        ovf;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;
  int     cyc;
  int     errors;
  int     checks;

  logic [96:0] exp_q[$];
  int          due_q[$];
  logic [31:0] model_hi;
  logic [31:0] model_lo;
  vec_t        vecs[19];

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: plain 64-bit arithmetic
  function automatic logic [96:0] model(input logic [3:0] op, input logic [31:0] x,
                                        input logic [31:0] y, input logic [4:0] sh,
                                        input logic [31:0] cur_hi, input logic [31:0] cur_lo);
    longint sx, sy, s;
    logic [63:0] p;
    logic [31:0] r, h, l;
    logic v;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = 32'd0; v = 1'b0; h = cur_hi; l = cur_lo; p = 64'd0;
    case (op)
      OP_ADD:  begin s = sx + sy; r = x + y; v = (s > SMAX) || (s < SMIN); end
      OP_SUB:  begin s = sx - sy; r = x - y; v = (s > SMAX) || (s < SMIN); end
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_NOR:  r = ~(x | y);
      OP_LUI:  r = y << 16;
      OP_SLT:  r = (sx < sy) ? 32'd1 : 32'd0;
      OP_SLTU: r = (x < y) ? 32'd1 : 32'd0;
      OP_SLL:  r = y << sh;
      OP_SRL:  r = y >> sh;
      OP_SRA:  begin s = sy >>> sh; p = s; r = p[31:0]; end
      OP_MULT: begin s = sx * sy; p = s; h = p[63:32]; l = p[31:0]; r = l; end
      OP_MULTU: begin p = {32'd0, x} * {32'd0, y}; h = p[63:32]; l = p[31:0]; r = l; end
      OP_DIV: begin
        if (y == 32'd0) begin l = 32'hFFFFFFFF; h = x; end
        else begin s = sx / sy; p = s; l = p[31:0]; s = sx % sy; p = s; h = p[31:0]; end
        r = l;
      end
      default: begin
        if (y == 32'd0) begin l = 32'hFFFFFFFF; h = x; end
        else begin l = x / y; h = x % y; end
        r = l;
      end
    endcase
    return {r, v, h, l};
  endfunction

  // driver: present one request when in_ready, queue its expectation
  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] sh, input logic [96:0] e);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0x0 expected 0x1 (cycle %0d)", cyc);
      return;
    end
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.x = x;
    bus.y = y;
    bus.shamt = sh;
    exp_q.push_back(e);
    due_q.push_back(cyc + (is_muldiv(op) ? 33 : 1));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic issue_model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                             input logic [4:0] sh);
    logic [96:0] e;
    e = model(op, x, y, sh, model_hi, model_lo);
    model_hi = e[63:32];
    model_lo = e[31:0];
    issue(op, x, y, sh, e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0 (cycle %0d)", exp_q.size(), cyc);
      exp_q.delete();
      due_q.delete();
    end
  endtask

  // scoreboard: every out_valid pulse must match the oldest expectation
  initial begin
    logic [96:0] e;
    int d;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid: got result 0x%08h expected no pulse (cycle %0d)",
                   bus.result, cyc);
        end else begin
          e = exp_q.pop_front();
          d = due_q.pop_front();
          chk("latency", 32'(cyc), 32'(d));
          chk("result", bus.result, e[96:65]);
          chk("zero", 32'(bus.zero), 32'(e[96:65] == 32'd0));
          chk("ovf", 32'(bus.ovf), 32'(e[64]));
          chk("hi", bus.hi, e[63:32]);
          chk("lo", bus.lo, e[31:0]);
        end
      end
    end
  end

  task automatic chk_reset_values(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_result"}, bus.result, 32'd0);
    chk({tag, "_zero"}, 32'(bus.zero), 32'd1);
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
    chk({tag, "_hi"}, bus.hi, 32'd0);
    chk({tag, "_lo"}, bus.lo, 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.op = OP_ADD;
    bus.x = 32'd0;
    bus.y = 32'd0;
    bus.shamt = 5'd0;

    vecs[0]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b1, 32'h0, 32'h0};
    vecs[1]  = '{OP_SUB,  32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b0, 32'h0, 32'h0};
    vecs[2]  = '{OP_SRA,  32'h00000000, 32'h80000000, 5'd4,  32'hF8000000, 1'b0, 32'h0, 32'h0};
    vecs[3]  = '{OP_LUI,  32'h00000000, 32'h00001234, 5'd0,  32'h12340000, 1'b0, 32'h0, 32'h0};
    vecs[4]  = '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0, 32'h0, 32'h0};
    vecs[5]  = '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b0, 32'h0, 32'h0};
    vecs[6]  = '{OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'h00F000F0, 1'b0, 32'h0, 32'h0};
    vecs[7]  = '{OP_NOR,  32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFF, 1'b0, 32'h0, 32'h0};
    vecs[8]  = '{OP_SUB,  32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b1, 32'h0, 32'h0};
    vecs[9]  = '{OP_SLL,  32'h00000000, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 32'h0, 32'h0};
    vecs[10] = '{OP_SRL,  32'h00000000, 32'h80000000, 5'd31, 32'h00000001, 1'b0, 32'h0, 32'h0};
    vecs[11] = '{OP_MULT, 32'hFFFFFFFF, 32'h00000002, 5'd0,  32'hFFFFFFFE, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[12] = '{OP_MULTU,32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  32'h00000001, 1'b0, 32'hFFFFFFFE, 32'h00000001};
    vecs[13] = '{OP_DIVU, 32'd100,      32'd7,        5'd0,  32'd14,       1'b0, 32'd2,        32'd14};
    vecs[14] = '{OP_DIV,  32'hFFFFFFF9, 32'h00000002, 5'd0,  32'hFFFFFFFD, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[15] = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd0,  32'h80000000, 1'b0, 32'h00000000, 32'h80000000};
    vecs[16] = '{OP_DIV,  32'h00000005, 32'h00000000, 5'd0,  32'hFFFFFFFF, 1'b0, 32'h00000005, 32'hFFFFFFFF};
    vecs[17] = '{OP_DIV,  32'hFFFFFFFB, 32'h00000000, 5'd0,  32'hFFFFFFFF, 1'b0, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[18] = '{OP_OR,   32'h00000001, 32'h00000002, 5'd0,  32'h00000003, 1'b0, 32'hFFFFFFFB, 32'hFFFFFFFF};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_values("reset");

    // directed table
    for (int i = 0; i < 19; i++) begin
      issue(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].sh,
            {vecs[i].res, vecs[i].ovf, vecs[i].hi, vecs[i].lo});
    end
    drain();
    model_hi = 32'hFFFFFFFB;
    model_lo = 32'hFFFFFFFF;

    // MULT stall window: a held request with changing operands is ignored
    issue_model(OP_MULT, 32'hFFFFFFFF, 32'h00000002, 5'd0);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
      if (k == 5) chk("state_busy", 32'(dbg_state), 32'(S_BUSY));
      if (k == 33) chk("state_done", 32'(dbg_state), 32'(S_DONE));
      bus.in_valid = 1'b1;
      bus.op = OP_ADD;
      bus.x = 32'(k);
      bus.y = 32'h1234;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("in_ready_after", 32'(bus.in_ready), 32'd1);
    drain();

    // random ops against the reference model
    for (int i = 0; i < 80; i++) begin
      logic [3:0] op;
      logic [31:0] x, y;
      op = 4'($urandom_range(0, 15));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 7) == 0) y = 32'd0;
      if (op >= OP_DIV && $urandom_range(0, 1) == 1) y = 32'($urandom_range(1, 20));
      if ($urandom_range(0, 9) == 0) x = 32'h80000000;
      if ($urandom_range(0, 9) == 0) y = 32'hFFFFFFFF;
      issue_model(op, x, y, 5'($urandom_range(0, 31)));
    end
    drain();

    // reset in the middle of a MULT
    issue_model(OP_MULT, 32'd3, 32'd5, 5'd0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    due_q.delete();
    model_hi = 32'd0;
    model_lo = 32'd0;
    #1;
    chk_reset_values("midop_reset");
    @(negedge clk);
    rst_n = 1'b1;
    issue_model(OP_ADD, 32'd10, 32'd20, 5'd0);
    drain();
    repeat (40) @(negedge clk);
    chk("post_reset_hi", bus.hi, 32'd0);
    chk("post_reset_lo", bus.lo, 32'd0);
    chk("post_reset_ready", 32'(bus.in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
